// File: rtl/aes_round_key_sched.sv
// aes_round_key_sched
//   Expands an AES-128 cipher key into round keys 0..10 and streams them one
//   per valid/ready handshake to the round datapath. Each expansion step is
//   taken only on an accepted output, so backpressure freezes the schedule.
//   With REPLAY_EN the expanded keys are cached so later blocks under the same
//   key can restream them without re-expanding.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   key_in      128-bit cipher key, [127:96] = w0 .. [31:0] = w3
//   key_valid   key_in valid
//   key_ready   block can accept a new key (IDLE or HOLD)
//   replay_req  pulse in HOLD: restream cached keys 0..10
//   rk_out      current round key
//   rk_idx      index of rk_out, 0..10
//   rk_last     rk_valid and rk_idx == 10
//   rk_valid    rk_out valid
//   rk_ready    consumer accepts rk_out
//
// aes_sbox
//   Combinational AES byte S-box: multiplicative inverse in GF(2^8) followed
//   by the AES affine transform.
//   data  input byte
//   sub   substituted byte

module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   logic [7:0] sq;
   logic [7:0] inv;

   // inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0)
   always_comb begin
      sq  = data;
      inv = 8'h01;
      for (int unsigned k = 0; k < 7; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      sub = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes_round_key_sched #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter bit          REPLAY_EN  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic         replay_req,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         rk_valid,
   input  logic         rk_ready
);

   localparam logic [3:0] LAST_IDX = 4'd10;

   generate
      if (NUM_ROUNDS != 10) begin : g_bad_rounds
         $error("aes_round_key_sched supports only NUM_ROUNDS = 10");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, EXPAND, HOLD, REPLAY} state_t;

   state_t        state, state_nxt;
   logic          load, adv, replay_start;
   logic [3:0]    idx_inc;
   logic [7:0]    rcon;
   logic [31:0]   w0, w1, w2, w3, rot, sub_w, t;
   logic [31:0]   n0, n1, n2, n3;
   logic [127:0]  key_nxt;
   logic          cache_valid;
   logic [127:0]  cache_rd;

   // saturates at 10 so the cache read index never leaves the array
   assign idx_inc = (rk_idx == LAST_IDX) ? LAST_IDX : rk_idx + 4'd1;

   always_comb begin
      rcon = 8'h00;
      case (idx_inc)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // next round key, computed from the registered current key
   assign {w0, w1, w2, w3} = rk_out;
   assign rot = {w3[23:0], w3[31:24]};

   aes_sbox u_sbox0 (.data(rot[31:24]), .sub(sub_w[31:24]));
   aes_sbox u_sbox1 (.data(rot[23:16]), .sub(sub_w[23:16]));
   aes_sbox u_sbox2 (.data(rot[15:8]),  .sub(sub_w[15:8]));
   aes_sbox u_sbox3 (.data(rot[7:0]),   .sub(sub_w[7:0]));

   assign t       = sub_w ^ {rcon, 24'h000000};
   assign n0      = w0 ^ t;
   assign n1      = w1 ^ n0;
   assign n2      = w2 ^ n1;
   assign n3      = w3 ^ n2;
   assign key_nxt = {n0, n1, n2, n3};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      load         = 1'b0;
      adv          = 1'b0;
      replay_start = 1'b0;
      rk_valid     = 1'b0;
      key_ready    = 1'b0;
      case (state)
         IDLE, HOLD: begin
            key_ready = 1'b1;
            // a new key takes priority over a replay request
            if (key_valid) begin
               load      = 1'b1;
               state_nxt = EXPAND;
            end else if (state == HOLD && replay_req && cache_valid) begin
               replay_start = 1'b1;
               state_nxt    = REPLAY;
            end
         end
         EXPAND, REPLAY: begin
            rk_valid = 1'b1;
            if (rk_ready) begin
               if (rk_idx == LAST_IDX) state_nxt = REPLAY_EN ? HOLD : IDLE;
               else                    adv       = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      rk_last = rk_valid && (rk_idx == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rk_out <= '0;
         rk_idx <= '0;
      end else if (load) begin
         rk_out <= key_in;
         rk_idx <= '0;
      end else if (replay_start) begin
         rk_out <= cache_rd;
         rk_idx <= '0;
      end else if (adv) begin
         rk_out <= (state == REPLAY) ? cache_rd : key_nxt;
         rk_idx <= idx_inc;
      end
   end

   generate
      if (REPLAY_EN) begin : g_cache
         logic [127:0] cache [0:10];
         logic [3:0]   rd_idx;

         always_ff @(posedge clk) begin
            if (load)                       cache[0]       <= key_in;
            else if (adv && state == EXPAND) cache[idx_inc] <= key_nxt;
         end

         // cleared on load so a partially rewritten cache is never replayed
         always_ff @(posedge clk) begin
            if (rst || load)
               cache_valid <= 1'b0;
            else if (state == EXPAND && rk_ready && rk_idx == LAST_IDX)
               cache_valid <= 1'b1;
         end

         assign rd_idx   = (state == REPLAY) ? idx_inc : 4'd0;
         assign cache_rd = cache[rd_idx];
      end else begin : g_no_cache
         assign cache_valid = 1'b0;
         assign cache_rd    = '0;
      end
   endgenerate

endmodule

// File: tb/tb_aes_round_key_sched.sv
// Bench for aes_round_key_sched: stimulus pushes expected round keys into a
// scoreboard queue; a negedge monitor pops and compares on every handshake.
// Expected keys come from a word-wise FIPS-197 key expansion with an S-box
// derived by brute-force GF(2^8) inversion.

module tb_aes_round_key_sched;

   logic         clk;
   logic         rst;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         replay_req;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         rk_valid;
   logic         rk_ready;

   aes_round_key_sched #(.NUM_ROUNDS(10), .REPLAY_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .replay_req(replay_req), .rk_out(rk_out),
      .rk_idx(rk_idx), .rk_last(rk_last), .rk_valid(rk_valid), .rk_ready(rk_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      logic [3:0]   idx;
   } exp_t;

   exp_t         sb[$];
   int           checks;
   int           failures;
   logic [7:0]   sbox_tbl [256];
   logic [127:0] model_keys [11];
   bit           model_cache_valid;
   logic [127:0] seen [16];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ZERO_KEY = 128'h0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (((b >> i) & 8'd1) != 8'd0) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--)
         if (((p >> i) & 15'd1) != 15'd0) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic build_sbox();
      logic [7:0] xb, yb, inv;
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            yb = 8'(y);
            if (xb != 8'h00 && gmul(xb, yb) == 8'h01) inv = yb;
         end
         sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                           ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
   endfunction

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      w[0] = key[127:96];
      w[1] = key[95:64];
      w[2] = key[63:32];
      w[3] = key[31:0];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_keys();
      exp_t e;
      for (int r = 0; r < 11; r++) begin
         e.key = model_keys[r];
         e.idx = 4'(r);
         sb.push_back(e);
      end
   endtask

   // monitor: one comparison set per accepted round key
   always @(negedge clk) begin
      exp_t e;
      if (rk_valid && rk_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_handshake: got idx %0d key %h, expected none", rk_idx, rk_out);
         end else begin
            e = sb.pop_front();
            chk("rk_out", rk_out, e.key);
            chk("rk_idx", 128'(rk_idx), 128'(e.idx));
            chk("rk_last", 128'(rk_last), 128'(e.idx == 4'd10));
            seen[rk_idx] = rk_out;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] k, input bit with_replay);
      model_expand(k);
      model_cache_valid = 1'b1;
      push_keys();
      key_in     = k;
      key_valid  = 1'b1;
      replay_req = with_replay;
      tick();
      key_valid  = 1'b0;
      replay_req = 1'b0;
      chk("load_valid_latency", 128'(rk_valid), 128'(1'b1));
      chk("load_first_idx", 128'(rk_idx), 128'(4'd0));
   endtask

   task automatic do_replay();
      if (model_cache_valid) push_keys();
      replay_req = 1'b1;
      tick();
      replay_req = 1'b0;
      chk("replay_valid_latency", 128'(rk_valid), 128'(model_cache_valid));
      chk("replay_first_idx", 128'(rk_idx), 128'(4'd0));
   endtask

   // drive rk_ready until the last key is accepted; bounded by a cycle budget
   task automatic run_stream(input int bp_idx, input int bp_len, input bit rand_ready,
                             input bit noise, input int exp_cycles, input string tag);
      int           cycles, bp_done;
      bit           finished, stalled, hs_last;
      logic [127:0] prev_out;
      logic [3:0]   prev_idx;
      cycles   = 0;
      bp_done  = 0;
      finished = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (rk_valid) cycles++;
         if (bp_len > 0 && rk_valid && rk_idx == 4'(bp_idx) && bp_done < bp_len) begin
            rk_ready = 1'b0;
            bp_done++;
         end else begin
            rk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         if (noise) begin
            key_in     = {$urandom, $urandom, $urandom, $urandom};
            key_valid  = 1'($urandom_range(0, 1));
            replay_req = 1'($urandom_range(0, 1));
         end
         stalled  = rk_valid && !rk_ready;
         hs_last  = rk_valid && rk_ready && rk_last;
         prev_out = rk_out;
         prev_idx = rk_idx;
         tick();
         if (stalled) begin
            chk({tag, "_stall_out"}, rk_out, prev_out);
            chk({tag, "_stall_idx"}, 128'(rk_idx), 128'(prev_idx));
         end
         if (hs_last) begin
            finished = 1'b1;
            break;
         end
      end
      key_valid  = 1'b0;
      replay_req = 1'b0;
      rk_ready   = 1'b1;
      chk({tag, "_finished"}, 128'(finished), 128'(1'b1));
      if (exp_cycles > 0) chk({tag, "_cycles"}, 128'(cycles), 128'(exp_cycles));
      chk({tag, "_valid_after"}, 128'(rk_valid), 128'(1'b0));
      chk({tag, "_key_ready_after"}, 128'(key_ready), 128'(1'b1));
      chk({tag, "_sb_drained"}, 128'(sb.size()), 128'(0));
   endtask

   initial begin
      checks            = 0;
      failures          = 0;
      model_cache_valid = 1'b0;
      rst        = 1'b1;
      key_in     = '0;
      key_valid  = 1'b0;
      replay_req = 1'b0;
      rk_ready   = 1'b0;
      build_sbox();

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_rk_valid", 128'(rk_valid), 128'(1'b0));
      chk("reset_rk_out", rk_out, 128'h0);
      chk("reset_rk_idx", 128'(rk_idx), 128'(4'd0));
      chk("reset_rk_last", 128'(rk_last), 128'(1'b0));
      chk("reset_key_ready", 128'(key_ready), 128'(1'b1));
      rk_ready = 1'b1;

      // FIPS-197 key, consumer always ready
      load_key(FIPS_KEY, 1'b0);
      run_stream(0, 0, 1'b0, 1'b0, 11, "fips");
      chk("fips_idx0", seen[0], FIPS_KEY);
      chk("fips_idx1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("fips_idx10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // replay of cached FIPS keys, with key_valid/replay_req noise ignored
      do_replay();
      run_stream(0, 0, 1'b0, 1'b1, 11, "replay");

      // key_valid and replay_req together in HOLD: the new key wins
      load_key(ZERO_KEY, 1'b1);
      run_stream(0, 0, 1'b0, 1'b0, 11, "zero");
      chk("zero_idx1", seen[1], 128'h62636363626363636263636362636363);
      chk("zero_idx10", seen[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      do_replay();
      run_stream(0, 0, 1'b0, 1'b0, 11, "zero_replay");
      chk("zero_replay_idx10", seen[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // backpressure at idx4 for 3 cycles
      load_key(FIPS_KEY, 1'b0);
      run_stream(4, 3, 1'b0, 1'b0, 14, "bp");
      chk("bp_idx10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // reset mid-stream at idx6
      load_key(FIPS_KEY, 1'b0);
      for (int c = 0; c < 20 && !(rk_valid && rk_idx == 4'd6); c++) tick();
      chk("reach_idx6", 128'(rk_idx), 128'(4'd6));
      rk_ready = 1'b0;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      rk_ready = 1'b1;
      sb.delete();
      model_cache_valid = 1'b0;
      chk("rst_mid_valid", 128'(rk_valid), 128'(1'b0));
      chk("rst_mid_idx", 128'(rk_idx), 128'(4'd0));
      chk("rst_mid_key_ready", 128'(key_ready), 128'(1'b1));
      do_replay();
      tick();
      chk("rst_replay_ignored", 128'(rk_valid), 128'(1'b0));
      load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      run_stream(0, 0, 1'b0, 1'b0, 11, "post_rst");

      // randomized keys and consumer stalls, each followed by a replay
      for (int n = 0; n < 6; n++) begin
         load_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
         run_stream(0, 0, 1'b1, 1'b1, 0, "rand");
         do_replay();
         run_stream(0, 0, 1'b1, 1'b1, 0, "rand_replay");
      end

      repeat (3) tick();
      chk("final_sb_empty", 128'(sb.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
